hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Parametrised next-generation pipeline hazard controller for the 5-stage RISC-V core. It keeps E-stage operand forwarding and load-use detection. It adds three things:
- a register scoreboard for multi-cycle (mul/div) ops that write back out of band;
- an outstanding-op counter with back-pressure;
- a redirect-pending FSM that defers flushes when a branch resolves during an I-cache miss whose replacement is not permitted.
It sits beside the datapath and drives all stall, flush and forward controls.

Parameters:
REG_ADDR_W, 5, register index width
NUM_REGS, 32, architectural registers (2**REG_ADDR_W)
MC_MAX, 2, max multi-cycle ops in flight (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
instr_hit_f_i  in  1  I-cache hit for F-stage fetch
rs1_d_i, rs2_d_i, rd_d_i  in  REG_ADDR_W each  D-stage source/dest registers
mc_op_d_i  in  1  D-stage instruction is multi-cycle
rs1_e_i, rs2_e_i, rd_e_i  in  REG_ADDR_W each  E-stage registers
load_e_i  in  1  E-stage instruction is a load
mc_issue_e_i  in  1  E-stage instruction issues to the multi-cycle unit
redirect_e_i  in  1  E-stage taken branch/jump mispredict redirect
ic_repl_permit_i  in  1  I-cache may abandon the current refill
rd_m_i, rd_w_i  in  REG_ADDR_W each  M/W destination registers
reg_write_m_i, reg_write_w_i  in  1 each  M/W write enables
mc_done_i  in  1  multi-cycle unit writes back this cycle
mc_rd_i  in  REG_ADDR_W  multi-cycle writeback destination
stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o  out  1 each  stage stalls
flush_d_o, flush_e_o  out  1 each  stage flushes
forward_a_e_o, forward_b_e_o  out  2 each  00 none, 01 W, 10 M
sb_busy_o  out  NUM_REGS  scoreboard busy vector
mc_count_o  out  $clog2(MC_MAX+1)  ops in flight
redirect_pend_o  out  1  FSM in PEND
sb_err_o  out  1  sticky protocol error

Behaviour:
- Reset (sync, reset_i=1 at edge):
  - sb_busy_o=0, mc_count_o=0, FSM=IDLE, sb_err_o=0.
  - Combinational outputs follow the equations below immediately.
- Forwarding (combinational):
  - M has priority over W.
  - Source x0 is never forwarded.
  - A source matching a register with write enable low is not forwarded.
- load_use = load_e_i & rd_e_i!=0 & (rs1_d_i==rd_e_i | rs2_d_i==rd_e_i).
- sb_haz, evaluated only for nonzero D indices:
  - busy[rs1_d_i] | busy[rs2_d_i] | busy[rd_d_i], or
  - mc_issue_e_i & rd_e_i!=0 & rd_e_i in {rs1_d_i, rs2_d_i, rd_d_i}.
- mc_full = mc_op_d_i & (mc_count_o==MC_MAX).
- haz_d = load_use | sb_haz | mc_full; miss = ~instr_hit_f_i; pend = (FSM==PEND).
- stall_f_o = (haz_d | miss) & ~redirect_e_i & ~pend
- stall_d_o = haz_d | miss
- stall_e_o = stall_m_o = stall_w_o = miss
- flush_d_o = (redirect_e_i & ~pend) | (pend & ~miss)
- flush_e_o = (haz_d & ~miss) | (redirect_e_i & ~pend & (~miss | ic_repl_permit_i)) | (pend & ~miss)
- FSM:
  - IDLE->PEND when redirect_e_i & miss & ~ic_repl_permit_i.
  - PEND->IDLE on the first cycle with instr_hit_f_i=1. The deferred flush fires in that cycle.
  - redirect_e_i is ignored while in PEND, because E is stalled and holds the same instruction.
- Issue accepted = mc_issue_e_i & rd_e_i!=0 & ~stall_e_o & ~flush_e_o. It sets busy[rd_e_i] at the next edge.
- mc_done_i clears busy[mc_rd_i] at the next edge.
- Counter:
  - +1 on accepted issue, -1 on done; both in the same cycle leave it unchanged.
  - Never exceeds MC_MAX and never goes below 0. This holds because issue is gated by mc_full one stage earlier.
- Same-register set and clear in one cycle is impossible by the sb_haz construction. If it occurs anyway, set wins.
- sb_err_o is set, sticky until reset, when:
  - mc_done_i with busy[mc_rd_i]==0 or count==0 (count and busy are then not changed), or
  - an accepted issue with count==MC_MAX.
- Reset asserted mid-operation discards all pending state, including PEND. No deferred flush is emitted.

Test Plan:
- Load in E with rd_e=5, D reads rs1=5 -> stall_f=stall_d=flush_e=1 for one cycle. A load with rd_e=0 -> no stall.
- Issue mul rd=7 (accepted); next instruction reads x7 -> sb_busy_o[7]=1 and stall_d=1 until mc_done_i with mc_rd=7. The stall drops the cycle after done.
- MC_MAX=2: two accepted issues -> mc_count_o=2. A third mc_op_d -> stall_d=1. Simultaneous done and issue -> count stays 2.
- redirect_e=1, instr_hit_f=0, ic_repl_permit=0 -> flush_d=1, flush_e=0, redirect_pend_o=1. Three miss cycles later instr_hit_f=1 -> flush_d=flush_e=1 that cycle, then IDLE.
- M and W both write x3 and rs2_e=3 -> forward_b_e=10. With reg_write_m=0 -> 01. rs2_e=0 -> 00.
- mc_done_i with mc_rd=9 while busy[9]=0 -> sb_err_o=1, held through later cycles, cleared only by reset_i.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// Control bundle between the 5-stage datapath and the hazard controller.
// The datapath owns the master side, the controller the slave side.
interface hazard_ctrl_mc_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MC_MAX     = 2
);
    localparam int CNT_W = $clog2(MC_MAX + 1);

    logic                  instr_hit_f_i;
    logic [REG_ADDR_W-1:0] rs1_d_i, rs2_d_i, rd_d_i;
    logic                  mc_op_d_i;
    logic [REG_ADDR_W-1:0] rs1_e_i, rs2_e_i, rd_e_i;
    logic                  load_e_i;
    logic                  mc_issue_e_i;
    logic                  redirect_e_i;
    logic                  ic_repl_permit_i;
    logic [REG_ADDR_W-1:0] rd_m_i, rd_w_i;
    logic                  reg_write_m_i, reg_write_w_i;
    logic                  mc_done_i;
    logic [REG_ADDR_W-1:0] mc_rd_i;

    logic                  stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o;
    logic                  flush_d_o, flush_e_o;
    logic [1:0]            forward_a_e_o, forward_b_e_o;
    logic [NUM_REGS-1:0]   sb_busy_o;
    logic [CNT_W-1:0]      mc_count_o;
    logic                  redirect_pend_o;
    logic                  sb_err_o;

    modport slave (
        input  instr_hit_f_i, rs1_d_i, rs2_d_i, rd_d_i, mc_op_d_i,
               rs1_e_i, rs2_e_i, rd_e_i, load_e_i, mc_issue_e_i,
               redirect_e_i, ic_repl_permit_i, rd_m_i, rd_w_i,
               reg_write_m_i, reg_write_w_i, mc_done_i, mc_rd_i,
        output stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
               flush_d_o, flush_e_o, forward_a_e_o, forward_b_e_o,
               sb_busy_o, mc_count_o, redirect_pend_o, sb_err_o
    );

    modport master (
        output instr_hit_f_i, rs1_d_i, rs2_d_i, rd_d_i, mc_op_d_i,
               rs1_e_i, rs2_e_i, rd_e_i, load_e_i, mc_issue_e_i,
               redirect_e_i, ic_repl_permit_i, rd_m_i, rd_w_i,
               reg_write_m_i, reg_write_w_i, mc_done_i, mc_rd_i,
        input  stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
               flush_d_o, flush_e_o, forward_a_e_o, forward_b_e_o,
               sb_busy_o, mc_count_o, redirect_pend_o, sb_err_o
    );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: forwarding, load-use, multi-cycle scoreboard with
// in-flight limit, and deferral of redirect flushes across unabortable I-cache refills.
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int MC_MAX     = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    hazard_ctrl_mc_if.slave  hz
);
    localparam int CNT_W = $clog2(MC_MAX + 1);

    typedef enum logic {IDLE, PEND} state_e;

    state_e                state_q;
    logic                  pend_q;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;

    logic miss, pend, load_use, sb_haz, mc_full, haz_d;
    logic busy_src, issue_match, mc_at_max;
    logic issue_acc, done_ok, done_bad;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (we_m && rd_m == rs)      sel = 2'b10;
            else if (we_w && rd_w == rs) sel = 2'b01;
        end
        return sel;
    endfunction

    assign hz.forward_a_e_o = fwd_sel(hz.rs1_e_i, hz.rd_m_i, hz.reg_write_m_i,
                                      hz.rd_w_i, hz.reg_write_w_i);
    assign hz.forward_b_e_o = fwd_sel(hz.rs2_e_i, hz.rd_m_i, hz.reg_write_m_i,
                                      hz.rd_w_i, hz.reg_write_w_i);

    assign miss      = ~hz.instr_hit_f_i;
    assign pend      = (state_q == PEND);
    assign mc_at_max = (count_q == CNT_W'(MC_MAX));

    assign load_use = hz.load_e_i && (hz.rd_e_i != '0) &&
                      ((hz.rs1_d_i == hz.rd_e_i) || (hz.rs2_d_i == hz.rd_e_i));

    // x0 is never tracked, so only nonzero D-stage indices may raise a hazard.
    assign busy_src = ((hz.rs1_d_i != '0) && busy_q[hz.rs1_d_i]) ||
                      ((hz.rs2_d_i != '0) && busy_q[hz.rs2_d_i]) ||
                      ((hz.rd_d_i  != '0) && busy_q[hz.rd_d_i]);
    assign issue_match = hz.mc_issue_e_i && (hz.rd_e_i != '0) &&
                         ((hz.rd_e_i == hz.rs1_d_i) || (hz.rd_e_i == hz.rs2_d_i) ||
                          (hz.rd_e_i == hz.rd_d_i));
    assign sb_haz  = busy_src || issue_match;
    assign mc_full = hz.mc_op_d_i && mc_at_max;
    assign haz_d   = load_use || sb_haz || mc_full;

    assign hz.stall_f_o = (haz_d || miss) && !hz.redirect_e_i && !pend;
    assign hz.stall_d_o = haz_d || miss;
    assign hz.stall_e_o = miss;
    assign hz.stall_m_o = miss;
    assign hz.stall_w_o = miss;
    assign hz.flush_d_o = (hz.redirect_e_i && !pend) || (pend && !miss);
    assign hz.flush_e_o = (haz_d && !miss) ||
                          (hz.redirect_e_i && !pend && (!miss || hz.ic_repl_permit_i)) ||
                          (pend && !miss);

    assign issue_acc = hz.mc_issue_e_i && (hz.rd_e_i != '0) && !hz.stall_e_o && !hz.flush_e_o;
    assign done_ok   = hz.mc_done_i && busy_q[hz.mc_rd_i] && (count_q != '0);
    assign done_bad  = hz.mc_done_i && !done_ok;

    // Clear before set so a same-cycle set on the same register wins.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        err_d   = err_q;
        if (done_ok)   busy_d[hz.mc_rd_i] = 1'b0;
        if (issue_acc) busy_d[hz.rd_e_i]  = 1'b1;
        if (issue_acc && !done_ok && !mc_at_max)
            count_d = count_q + CNT_W'(1);
        else if (done_ok && !issue_acc)
            count_d = count_q - CNT_W'(1);
        if (done_bad || (issue_acc && mc_at_max))
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // While PEND, E is stalled on the same redirect, so redirect_e_i is ignored.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (hz.redirect_e_i && miss && !hz.ic_repl_permit_i) begin
                    state_q <= PEND;
                    pend_q  <= 1'b1;
                end
                PEND: if (!miss) begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hz.sb_busy_o       = busy_q;
    assign hz.mc_count_o      = count_q;
    assign hz.redirect_pend_o = pend_q;
    assign hz.sb_err_o        = err_q;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl_mc;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int MC_MAX     = 2;

    localparam logic [5:0] C_CTL = 6'b000001;
    localparam logic [5:0] C_FWD = 6'b000010;
    localparam logic [5:0] C_BSY = 6'b000100;
    localparam logic [5:0] C_CNT = 6'b001000;
    localparam logic [5:0] C_PND = 6'b010000;
    localparam logic [5:0] C_ERR = 6'b100000;

    typedef struct {
        string       name;
        logic [5:0]  care;
        logic [6:0]  ctl;   // {stall_f,d,e,m,w, flush_d, flush_e}
        logic [3:0]  fwd;   // {forward_a, forward_b}
        logic [31:0] busy;
        logic [1:0]  cnt;
        logic        pend;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t expQ[$];

    hazard_ctrl_mc_if #(.REG_ADDR_W(REG_ADDR_W), .NUM_REGS(NUM_REGS), .MC_MAX(MC_MAX)) bus ();

    hazard_ctrl_mc #(.REG_ADDR_W(REG_ADDR_W), .NUM_REGS(NUM_REGS), .MC_MAX(MC_MAX)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .hz      (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(input string name, input logic [5:0] care,
                                   input logic [6:0] ctl, input logic [3:0] fwd,
                                   input logic [31:0] busy, input logic [1:0] cnt,
                                   input logic pend, input logic err);
        exp_t e;
        e.name = name; e.care = care; e.ctl = ctl; e.fwd = fwd;
        e.busy = busy; e.cnt = cnt; e.pend = pend; e.err = err;
        return e;
    endfunction

    task automatic setDefaults();
        bus.instr_hit_f_i = 1'b1;
        bus.rs1_d_i = '0; bus.rs2_d_i = '0; bus.rd_d_i = '0;
        bus.mc_op_d_i = 1'b0;
        bus.rs1_e_i = '0; bus.rs2_e_i = '0; bus.rd_e_i = '0;
        bus.load_e_i = 1'b0; bus.mc_issue_e_i = 1'b0;
        bus.redirect_e_i = 1'b0; bus.ic_repl_permit_i = 1'b0;
        bus.rd_m_i = '0; bus.rd_w_i = '0;
        bus.reg_write_m_i = 1'b0; bus.reg_write_w_i = 1'b0;
        bus.mc_done_i = 1'b0; bus.mc_rd_i = '0;
    endtask

    // Inputs are already set by the caller; this queues the expectation for the cycle.
    task automatic applyStimulus(input exp_t e);
        expQ.push_back(e);
        @(posedge clk);
        #1;
        setDefaults();
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        setDefaults();
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] ctl;
        logic [3:0] fwd;
        ctl = {bus.stall_f_o, bus.stall_d_o, bus.stall_e_o, bus.stall_m_o,
               bus.stall_w_o, bus.flush_d_o, bus.flush_e_o};
        fwd = {bus.forward_a_e_o, bus.forward_b_e_o};
        if ((e.care & C_CTL) != 0) begin
            testsRun++;
            if (ctl !== e.ctl) begin
                testsFailed++;
                $display("[TB] FAIL %s ctl: got %b expected %b", e.name, ctl, e.ctl);
            end
        end
        if ((e.care & C_FWD) != 0) begin
            testsRun++;
            if (fwd !== e.fwd) begin
                testsFailed++;
                $display("[TB] FAIL %s fwd: got %b expected %b", e.name, fwd, e.fwd);
            end
        end
        if ((e.care & C_BSY) != 0) begin
            testsRun++;
            if (bus.sb_busy_o !== e.busy) begin
                testsFailed++;
                $display("[TB] FAIL %s busy: got %h expected %h", e.name, bus.sb_busy_o, e.busy);
            end
        end
        if ((e.care & C_CNT) != 0) begin
            testsRun++;
            if (bus.mc_count_o !== e.cnt) begin
                testsFailed++;
                $display("[TB] FAIL %s count: got %0d expected %0d", e.name, bus.mc_count_o, e.cnt);
            end
        end
        if ((e.care & C_PND) != 0) begin
            testsRun++;
            if (bus.redirect_pend_o !== e.pend) begin
                testsFailed++;
                $display("[TB] FAIL %s pend: got %b expected %b", e.name, bus.redirect_pend_o, e.pend);
            end
        end
        if ((e.care & C_ERR) != 0) begin
            testsRun++;
            if (bus.sb_err_o !== e.err) begin
                testsFailed++;
                $display("[TB] FAIL %s err: got %b expected %b", e.name, bus.sb_err_o, e.err);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && expQ.size() != 0) checkOutput(expQ.pop_front());
    end

    initial begin
        setDefaults();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(mkExp("reset", 6'b111111, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Load-use
        bus.load_e_i = 1'b1; bus.rd_e_i = 5'd5; bus.rs1_d_i = 5'd5;
        applyStimulus(mkExp("load_use", C_CTL, 7'b1100001, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.load_e_i = 1'b1; bus.rd_e_i = 5'd0;
        applyStimulus(mkExp("load_x0", C_CTL, 7'b0000000, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Scoreboard dependency on x7
        bus.mc_issue_e_i = 1'b1; bus.rd_e_i = 5'd7;
        bus.rs1_d_i = 5'd1; bus.rs2_d_i = 5'd2; bus.rd_d_i = 5'd3;
        applyStimulus(mkExp("mul_issue", C_CTL | C_BSY | C_CNT, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.rs1_d_i = 5'd7;
        applyStimulus(mkExp("mul_dep", C_CTL | C_BSY | C_CNT, 7'b1100001, 4'b0, 32'h80, 2'd1, 1'b0, 1'b0));
        bus.rs1_d_i = 5'd7;
        applyStimulus(mkExp("mul_dep2", C_CTL | C_BSY, 7'b1100001, 4'b0, 32'h80, 2'd1, 1'b0, 1'b0));
        bus.rs1_d_i = 5'd7; bus.mc_done_i = 1'b1; bus.mc_rd_i = 5'd7;
        applyStimulus(mkExp("mul_done", C_CTL | C_BSY, 7'b1100001, 4'b0, 32'h80, 2'd1, 1'b0, 1'b0));
        bus.rs1_d_i = 5'd7;
        applyStimulus(mkExp("after_done", C_CTL | C_BSY | C_CNT | C_ERR, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Fill the multi-cycle unit
        bus.mc_issue_e_i = 1'b1; bus.rd_e_i = 5'd10;
        applyStimulus(mkExp("issue10", C_CTL | C_CNT, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.mc_issue_e_i = 1'b1; bus.rd_e_i = 5'd11;
        applyStimulus(mkExp("issue11", C_CTL | C_CNT | C_BSY, 7'b0, 4'b0, 32'h400, 2'd1, 1'b0, 1'b0));
        bus.mc_op_d_i = 1'b1; bus.rd_d_i = 5'd12;
        applyStimulus(mkExp("mc_full", C_CTL | C_CNT | C_BSY, 7'b1100001, 4'b0, 32'hC00, 2'd2, 1'b0, 1'b0));
        bus.mc_done_i = 1'b1; bus.mc_rd_i = 5'd10; bus.mc_issue_e_i = 1'b1; bus.rd_e_i = 5'd13;
        applyStimulus(mkExp("done_issue", C_CTL | C_CNT, 7'b0, 4'b0, 32'h0, 2'd2, 1'b0, 1'b0));
        applyStimulus(mkExp("count_hold", C_CTL | C_CNT | C_BSY, 7'b0, 4'b0, 32'h2800, 2'd2, 1'b0, 1'b0));
        bus.mc_done_i = 1'b1; bus.mc_rd_i = 5'd11;
        applyStimulus(mkExp("done11", C_CNT, 7'b0, 4'b0, 32'h0, 2'd2, 1'b0, 1'b0));
        bus.mc_done_i = 1'b1; bus.mc_rd_i = 5'd13;
        applyStimulus(mkExp("done13", C_CNT | C_BSY, 7'b0, 4'b0, 32'h2000, 2'd1, 1'b0, 1'b0));
        applyStimulus(mkExp("drained", C_CNT | C_BSY, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        doReset();
        applyStimulus(mkExp("reset2", C_ERR | C_CNT | C_PND, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Deferred redirect across an unabortable miss
        bus.redirect_e_i = 1'b1; bus.instr_hit_f_i = 1'b0;
        applyStimulus(mkExp("redir_miss", C_CTL | C_PND, 7'b0111110, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            bus.redirect_e_i = 1'b1; bus.instr_hit_f_i = 1'b0;
            applyStimulus(mkExp("pend_miss", C_CTL | C_PND, 7'b0111100, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        end
        bus.redirect_e_i = 1'b1;
        applyStimulus(mkExp("pend_hit", C_CTL | C_PND, 7'b0000011, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        applyStimulus(mkExp("pend_done", C_CTL | C_PND, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Redirect with permitted refill abandonment, and with a hit
        bus.redirect_e_i = 1'b1; bus.instr_hit_f_i = 1'b0; bus.ic_repl_permit_i = 1'b1;
        applyStimulus(mkExp("redir_permit", C_CTL, 7'b0111111, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        applyStimulus(mkExp("permit_idle", C_CTL | C_PND, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.redirect_e_i = 1'b1;
        applyStimulus(mkExp("redir_hit", C_CTL, 7'b0000011, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Forwarding
        bus.rd_m_i = 5'd3; bus.rd_w_i = 5'd3; bus.reg_write_m_i = 1'b1; bus.reg_write_w_i = 1'b1;
        bus.rs2_e_i = 5'd3;
        applyStimulus(mkExp("fwd_m", C_FWD | C_CTL, 7'b0, 4'b0010, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.rd_m_i = 5'd3; bus.rd_w_i = 5'd3; bus.reg_write_w_i = 1'b1; bus.rs2_e_i = 5'd3;
        applyStimulus(mkExp("fwd_w", C_FWD, 7'b0, 4'b0001, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.rd_m_i = 5'd0; bus.rd_w_i = 5'd0; bus.reg_write_m_i = 1'b1; bus.reg_write_w_i = 1'b1;
        applyStimulus(mkExp("fwd_x0", C_FWD, 7'b0, 4'b0000, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.rs1_e_i = 5'd4; bus.rd_w_i = 5'd4; bus.reg_write_w_i = 1'b1;
        bus.rd_m_i = 5'd5; bus.reg_write_m_i = 1'b1;
        applyStimulus(mkExp("fwd_a_w", C_FWD, 7'b0, 4'b0100, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.rs1_e_i = 5'd4; bus.rd_w_i = 5'd4; bus.reg_write_w_i = 1'b0;
        applyStimulus(mkExp("fwd_a_we0", C_FWD, 7'b0, 4'b0000, 32'h0, 2'd0, 1'b0, 1'b0));

        // Sticky protocol error
        bus.mc_done_i = 1'b1; bus.mc_rd_i = 5'd9;
        applyStimulus(mkExp("bad_done", C_ERR, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        applyStimulus(mkExp("err_set", C_ERR | C_CNT | C_BSY, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b1));
        applyStimulus(mkExp("err_hold", C_ERR, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b1));
        doReset();
        applyStimulus(mkExp("err_clr", C_ERR, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        // Reset while PEND drops the deferred flush
        bus.redirect_e_i = 1'b1; bus.instr_hit_f_i = 1'b0;
        applyStimulus(mkExp("redir_miss2", C_CTL, 7'b0111110, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));
        bus.instr_hit_f_i = 1'b0;
        applyStimulus(mkExp("pend2", C_PND, 7'b0, 4'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        bus.instr_hit_f_i = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        setDefaults();
        applyStimulus(mkExp("no_deferred", C_CTL | C_PND, 7'b0, 4'b0, 32'h0, 2'd0, 1'b0, 1'b0));

        for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
